sd_card_init: RTL and testbench
===============================

# sd_card_init

SPI-mode SD card initialisation engine for the SD→DDR→VGA picture path. It runs the power-up and identification sequence: ≥74 dummy clocks, CMD0, CMD8, the CMD55/ACMD41 loop and, optionally, CMD58. It then raises `init`, which releases the sector reader to start CMD17 block reads. While `init` is low the top level routes this block's `SD_cs`/`SD_datain` to the card; after that it routes the reader's.

## Interface
- `POWERUP_CYC`, 160: SD_clk cycles with CS and DI high before CMD0.
- `RESP_TIMEOUT`, 80: clocks to wait for an R1 start bit after a command.
- `CMD_RETRY`, 8: CMD0/CMD8 attempts before error.
- `ACMD41_MAX`, 2000: CMD55/ACMD41 iterations before error.
- `SD_clk  in  1`: SPI clock, ≤400 kHz during init. It is the only clock.
- `rst  in  1`: reset, synchronous and active-high.
- `SD_dataout  in  1`: card DO (MISO).
- `SD_cs  out  1`: card chip select, active-low.
- `SD_datain  out  1`: card DI (MOSI).
- `init  out  1`: initialisation complete. Sticky until `rst`.
- `init_err  out  1`: sequence failed. Sticky until `rst`.
- `card_v2  out  1`: card accepted CMD8.
- `card_hc  out  1`: block-addressed (SDHC/SDXC) card.
- `init_state  out  4`: current state, for debug.

## Operation
- **States:**
  - RESET=0
  - POWERUP=1
  - CMD0=2
  - CMD8=3
  - CMD55=4
  - ACMD41=5
  - CMD58=6
  - GAP=7
  - DONE=8
  - ERROR=9
- **Command frames** are 48 bits, sent MSB first:
  - CMD0: 0x40_00000000_95
  - CMD8: 0x48_000001AA_87
  - CMD55: 0x77_00000000_01
  - ACMD41: 0x69_HCS<<30_01, where HCS=`card_v2`
  - CMD58: 0x7A_00000000_01
- **Response capture:**
  - After the last command bit, DI is held high and DO is polled. The first 0 bit is R1 bit 7.
  - 8 bits are captured. For CMD8 (R7) and CMD58 (R3), 32 more bits are captured.
  - If no 0 bit arrives within `RESP_TIMEOUT` clocks, the command counts as timed out.
- **Transitions:**
  - POWERUP → CMD0 after `POWERUP_CYC` clocks with CS=1 and DI=1.
  - CMD0:
    - R1=0x01 → CMD8.
    - Timeout or any other R1 → CMD0 again, up to `CMD_RETRY` attempts, then ERROR.
  - CMD8:
    - R1=0x01 with echo[11:0]=0x1AA → `card_v2`=1, then CMD55.
    - R1 bit 2 set (illegal command) → `card_v2`=0, then CMD55.
    - Echo mismatch → ERROR.
    - Timeout → retry as for CMD0.
  - CMD55: R1 of 0x01 or 0x00 → ACMD41. Anything else → ERROR.
  - ACMD41:
    - R1=0x00 → CMD58. If CMD58 is compiled out, go straight to DONE.
    - R1=0x01 → back to CMD55, incrementing the loop counter. When the counter reaches `ACMD41_MAX` → ERROR.
  - CMD58: R1=0x00 → `card_hc`=OCR[30], then DONE.
- **GAP:** every command is followed by GAP, which drives CS=1 and DI=1 for 8 clocks before the next command starts.
- **DONE:** `init`=1, CS=1, DI=1. The block stays here until `rst`.
- **ERROR:** `init_err`=1, `init`=0, CS=1, DI=1. The block stays here until `rst`.

## Timing
- **Clock edges:**
  - `SD_cs` and `SD_datain` are launched on the falling edge of `SD_clk`, so the card samples them on the rising edge.
  - All other state, including response sampling, updates on the rising edge.
- **Reset:**
  - `rst` is sampled on both edges. The cycle after it is seen, outputs are: `SD_cs`=1, `SD_datain`=1, `init`=0, `init_err`=0, `card_v2`=0, `card_hc`=0, `init_state`=0.
  - RESET → POWERUP occurs one clock after `rst` deasserts.
  - Asserting `rst` mid-command aborts the frame immediately, with no partial-frame completion.
- **Command frame:**
  - CS falls on the same falling edge that launches bit 47.
  - 48 clocks of command are followed by up to `RESP_TIMEOUT` clocks of polling, then 7 or 39 capture clocks.
- **Flag timing:**
  - `init` rises on the rising edge after the last GAP clock that follows the final successful response.
  - `init` and `init_err` are never both high.
- **Counters:** the retry and loop counters saturate; they do not wrap. The ACMD41 counter is 11 bits wide.

## Configuration
- **`SD_CCS_READ_EN`**
  - Defined: the CMD58 state is built in and `card_hc` = OCR bit 30.
  - Undefined: the CMD58 state is removed, ACMD41 success goes directly through GAP to DONE, and `card_hc` = `card_v2`.

## Structure
- **Package `sd_pkg`:**
  - State encoding constants.
  - 48-bit command frame constants for CMD0, CMD8, CMD55, ACMD41 (base value) and CMD58.
  - R1 bit-position constants.
  - The 0x1AA check pattern.
  - Shared by the sector reader's CMD17 construction.
- **Sub-module `sd_cmd_if`:**
  - Takes a `start` pulse, a 48-bit frame and a `long_resp` flag.
  - Shifts the frame out, polls with timeout, and captures R1 plus 32 bits.
  - Returns `done`, `timeout`, `r1[7:0]` and `resp[31:0]`.
  - The top-level FSM only sequences commands and decides on the results.

## Test plan
- **v2 SDHC card:**
  - Card model returns 0x01; then 0x01 with echo 0x000001AA; ACMD41 0x01 twice then 0x00; OCR 0xC0FF8000.
  - Expect: ≥160 clocks with CS=1 before the first CS fall; `init`=1; `card_v2`=1; `card_hc`=1.
- **v1 card:**
  - CMD8 R1=0x05.
  - Expect: ACMD41 argument 0x00000000; `card_v2`=0; `init`=1; `card_hc`=0 in both macro builds.
- **Dead card:**
  - DO held at 1.
  - Expect: exactly 8 CMD0 frames, each followed by 80 poll clocks; then `init_err`=1 with CS=1.
- **ACMD41 stuck:**
  - ACMD41 always answers 0x01 (with `ACMD41_MAX` set to 5 on the bench).
  - Expect: 5 CMD55/ACMD41 pairs, then `init_err`=1.
- **CMD8 echo mismatch:**
  - Echo 0x000001AB.
  - Expect: ERROR with no CMD55 issued.
- **Reset mid-sequence:**
  - Assert `rst` during bit 20 of ACMD41.
  - Expect: the next cycle shows CS=1, DI=1, `init_state`=0; then a full POWERUP is repeated.

Source files
------------

// File: rtl/sd_pkg.sv
// Shared definitions for the SPI-mode SD card path: state encodings, command
// frames, R1 bit positions and the CMD8 check pattern. The sector reader uses
// the same frame layout when it builds CMD17.
package sd_pkg;

    typedef enum logic [3:0] {
        ST_RESET   = 4'd0,
        ST_POWERUP = 4'd1,
        ST_CMD0    = 4'd2,
        ST_CMD8    = 4'd3,
        ST_CMD55   = 4'd4,
        ST_ACMD41  = 4'd5,
        ST_CMD58   = 4'd6,
        ST_GAP     = 4'd7,
        ST_DONE    = 4'd8,
        ST_ERROR   = 4'd9
    } sd_state_t;

    typedef enum logic [2:0] {
        IF_IDLE = 3'd0,
        IF_SEND = 3'd1,
        IF_POLL = 3'd2,
        IF_CAPT = 3'd3,
        IF_FIN  = 3'd4
    } if_state_t;

    // 48-bit frames: start/index byte, 32-bit argument, CRC7 + end bit.
    localparam logic [47:0] FRAME_CMD0        = 48'h40_00000000_95;
    localparam logic [47:0] FRAME_CMD8        = 48'h48_000001AA_87;
    localparam logic [47:0] FRAME_CMD55       = 48'h77_00000000_01;
    localparam logic [47:0] FRAME_ACMD41_BASE = 48'h69_00000000_01;
    localparam logic [47:0] FRAME_CMD58       = 48'h7A_00000000_01;

    localparam int R1_IDLE_BIT    = 0;
    localparam int R1_ILLEGAL_BIT = 2;
    localparam logic [7:0] R1_IDLE  = 8'h01;
    localparam logic [7:0] R1_READY = 8'h00;

    localparam logic [11:0] CHECK_PATTERN = 12'h1AA;
    localparam int          GAP_CYC       = 8;

    // ACMD41 with HCS placed in argument bit 30 (frame bit 38).
    function automatic logic [47:0] acmd41_frame(input logic hcs);
        return FRAME_ACMD41_BASE | ({47'd0, hcs} << 38);
    endfunction

endpackage

// File: rtl/sd_cmd_if.sv
// Single-command SPI engine: shifts a 48-bit frame out MSB first, polls DO
// for the R1 start bit with a timeout, then captures R1 (and 32 more bits for
// long responses). CS/DI are launched on the falling edge of SD_clk.
// Handshake: start is honoured only while if_state is IF_IDLE; done is a
// one-cycle pulse (if_state IF_FIN) with timeout/r1/resp valid in that cycle.
module sd_cmd_if
    import sd_pkg::*;
#(
    parameter int RESP_TIMEOUT = 80
) (
    input  logic        SD_clk,
    input  logic        rst,
    input  logic        start,
    input  logic [47:0] frame,
    input  logic        long_resp,
    input  logic        SD_dataout,
    output logic        SD_cs,
    output logic        SD_datain,
    output logic        done,
    output logic        timeout,
    output logic [7:0]  r1,
    output logic [31:0] resp,
    output if_state_t   if_state
);

    localparam int PW = $clog2(RESP_TIMEOUT + 1);

    if_state_t      st_q, st_d;
    logic [47:0]    sh_q, sh_d;
    logic [5:0]     cnt_q, cnt_d;
    logic [PW-1:0]  poll_q, poll_d;
    logic [39:0]    cap_q, cap_d;
    logic           long_q, long_d;
    logic           to_q, to_d;
    logic           cs_d, di_d;

    // Next-state logic for send / poll / capture sequencing.
    always_comb begin
        st_d   = st_q;
        sh_d   = sh_q;
        cnt_d  = cnt_q;
        poll_d = poll_q;
        cap_d  = cap_q;
        long_d = long_q;
        to_d   = to_q;
        case (st_q)
            IF_IDLE: if (start) begin
                st_d   = IF_SEND;
                sh_d   = frame;
                cnt_d  = 6'd47;
                long_d = long_resp;
                to_d   = 1'b0;
            end
            IF_SEND: begin
                sh_d = {sh_q[46:0], 1'b1};
                if (cnt_q == 6'd0) begin
                    st_d   = IF_POLL;
                    poll_d = '0;
                end else begin
                    cnt_d = cnt_q - 6'd1;
                end
            end
            IF_POLL: begin
                if (!SD_dataout) begin
                    // The 0 just sampled is R1 bit 7; count the bits still to come.
                    st_d  = IF_CAPT;
                    cap_d = '0;
                    cnt_d = long_q ? 6'd39 : 6'd7;
                end else if (poll_q == PW'(RESP_TIMEOUT - 1)) begin
                    st_d = IF_FIN;
                    to_d = 1'b1;
                end else begin
                    poll_d = poll_q + PW'(1);
                end
            end
            IF_CAPT: begin
                cap_d = {cap_q[38:0], SD_dataout};
                cnt_d = cnt_q - 6'd1;
                if (cnt_q == 6'd1) st_d = IF_FIN;
            end
            IF_FIN:  st_d = IF_IDLE;
            default: st_d = IF_IDLE;
        endcase
    end

    // Rising-edge state; reset drops any frame in flight.
    always_ff @(posedge SD_clk) begin
        if (rst) begin
            st_q   <= IF_IDLE;
            sh_q   <= '1;
            cnt_q  <= '0;
            poll_q <= '0;
            cap_q  <= '0;
            long_q <= 1'b0;
            to_q   <= 1'b0;
        end else begin
            st_q   <= st_d;
            sh_q   <= sh_d;
            cnt_q  <= cnt_d;
            poll_q <= poll_d;
            cap_q  <= cap_d;
            long_q <= long_d;
            to_q   <= to_d;
        end
    end

    assign cs_d = !((st_q == IF_SEND) || (st_q == IF_POLL) || (st_q == IF_CAPT));
    assign di_d = (st_q == IF_SEND) ? sh_q[47] : 1'b1;

    // Launch CS/DI on the falling edge so the card samples them mid-bit.
    always_ff @(negedge SD_clk) begin
        if (rst) begin
            SD_cs     <= 1'b1;
            SD_datain <= 1'b1;
        end else begin
            SD_cs     <= cs_d;
            SD_datain <= di_d;
        end
    end

    assign done     = (st_q == IF_FIN);
    assign timeout  = to_q;
    assign r1       = long_q ? cap_q[39:32] : cap_q[7:0];
    assign resp     = cap_q[31:0];
    assign if_state = st_q;

endmodule

// File: rtl/sd_card_init.sv
// SD card SPI-mode initialisation sequencer: power-up clocks, CMD0, CMD8,
// CMD55/ACMD41 loop and (with SD_CCS_READ_EN defined) CMD58 to read CCS.
// Without SD_CCS_READ_EN, card_hc follows card_v2.
module sd_card_init
    import sd_pkg::*;
#(
    parameter int POWERUP_CYC  = 160,
    parameter int RESP_TIMEOUT = 80,
    parameter int CMD_RETRY    = 8,
    parameter int ACMD41_MAX   = 2000
) (
    input  logic       SD_clk,
    input  logic       rst,
    input  logic       SD_dataout,
    output logic       SD_cs,
    output logic       SD_datain,
    output logic       init,
    output logic       init_err,
    output logic       card_v2,
    output logic       card_hc,
    output logic [3:0] init_state
);

    localparam int CW = 16;
    localparam int RW = $clog2(CMD_RETRY + 1);

    sd_state_t      state_q, state_d, next_q, next_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [RW-1:0]  retry_q, retry_d;
    logic [10:0]    loop_q, loop_d;
    logic           v2_q, v2_d, hc_q, hc_d;

    logic           start, long_resp, cmd_state;
    logic [47:0]    frame;
    logic           cmd_done, cmd_timeout;
    logic [7:0]     cmd_r1;
    logic [31:0]    cmd_resp;
    if_state_t      if_state;
    logic           resp_unused;

    sd_cmd_if #(.RESP_TIMEOUT(RESP_TIMEOUT)) u_cmd (
        .SD_clk    (SD_clk),
        .rst       (rst),
        .start     (start),
        .frame     (frame),
        .long_resp (long_resp),
        .SD_dataout(SD_dataout),
        .SD_cs     (SD_cs),
        .SD_datain (SD_datain),
        .done      (cmd_done),
        .timeout   (cmd_timeout),
        .r1        (cmd_r1),
        .resp      (cmd_resp),
        .if_state  (if_state)
    );

    assign resp_unused = ^cmd_resp[31:12];
    assign cmd_state = (state_q == ST_CMD0) || (state_q == ST_CMD8) || (state_q == ST_CMD55) ||
                       (state_q == ST_ACMD41) || (state_q == ST_CMD58);

    // Sequencing: issue one command per state, judge its result, then GAP.
    always_comb begin
        state_d   = state_q;
        next_d    = next_q;
        cnt_d     = cnt_q;
        retry_d   = retry_q;
        loop_d    = loop_q;
        v2_d      = v2_q;
        hc_d      = hc_q;
        frame     = FRAME_CMD0;
        long_resp = 1'b0;
        start     = cmd_state && (if_state == IF_IDLE);
        if (cmd_state && cmd_done) begin
            state_d = ST_GAP;
            cnt_d   = '0;
        end
        case (state_q)
            ST_RESET: begin
                state_d = ST_POWERUP;
                cnt_d   = '0;
            end
            ST_POWERUP: begin
                if (cnt_q == CW'(POWERUP_CYC - 1)) begin
                    state_d = ST_CMD0;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_CMD0: begin
                frame = FRAME_CMD0;
                if (cmd_done) begin
                    if (!cmd_timeout && cmd_r1 == R1_IDLE) begin
                        retry_d = '0;
                        next_d  = ST_CMD8;
                    end else if (retry_q == RW'(CMD_RETRY - 1)) begin
                        next_d = ST_ERROR;
                    end else begin
                        retry_d = retry_q + RW'(1);
                        next_d  = ST_CMD0;
                    end
                end
            end
            ST_CMD8: begin
                frame     = FRAME_CMD8;
                long_resp = 1'b1;
                if (cmd_done) begin
                    if (cmd_timeout) begin
                        if (retry_q == RW'(CMD_RETRY - 1)) begin
                            next_d = ST_ERROR;
                        end else begin
                            retry_d = retry_q + RW'(1);
                            next_d  = ST_CMD8;
                        end
                    end else if (cmd_r1 == R1_IDLE && cmd_resp[11:0] == CHECK_PATTERN) begin
                        v2_d   = 1'b1;
                        next_d = ST_CMD55;
                    end else if (cmd_r1[R1_ILLEGAL_BIT]) begin
                        // Illegal command: a v1 card that does not know CMD8.
                        v2_d   = 1'b0;
                        next_d = ST_CMD55;
                    end else begin
                        next_d = ST_ERROR;
                    end
                end
            end
            ST_CMD55: begin
                frame = FRAME_CMD55;
                if (cmd_done) begin
                    if (!cmd_timeout && (cmd_r1 == R1_IDLE || cmd_r1 == R1_READY)) next_d = ST_ACMD41;
                    else next_d = ST_ERROR;
                end
            end
            ST_ACMD41: begin
                frame = acmd41_frame(v2_q);
                if (cmd_done) begin
                    if (!cmd_timeout && cmd_r1 == R1_READY) begin
`ifdef SD_CCS_READ_EN
                        next_d = ST_CMD58;
`else
                        hc_d   = v2_q;
                        next_d = ST_DONE;
`endif
                    end else if (!cmd_timeout && cmd_r1 == R1_IDLE) begin
                        if (loop_q == 11'(ACMD41_MAX - 1)) begin
                            next_d = ST_ERROR;
                        end else begin
                            loop_d = loop_q + 11'd1;
                            next_d = ST_CMD55;
                        end
                    end else begin
                        next_d = ST_ERROR;
                    end
                end
            end
`ifdef SD_CCS_READ_EN
            ST_CMD58: begin
                frame     = FRAME_CMD58;
                long_resp = 1'b1;
                if (cmd_done) begin
                    if (!cmd_timeout && cmd_r1 == R1_READY) begin
                        hc_d   = cmd_resp[30];
                        next_d = ST_DONE;
                    end else begin
                        next_d = ST_ERROR;
                    end
                end
            end
`endif
            ST_GAP: begin
                if (cnt_q == CW'(GAP_CYC - 1)) begin
                    state_d = next_q;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_DONE:  state_d = ST_DONE;
            ST_ERROR: state_d = ST_ERROR;
            default:  state_d = ST_RESET;
        endcase
    end

    // Sequencer state register with synchronous reset.
    always_ff @(posedge SD_clk) begin
        if (rst) begin
            state_q <= ST_RESET;
            next_q  <= ST_RESET;
            cnt_q   <= '0;
            retry_q <= '0;
            loop_q  <= '0;
            v2_q    <= 1'b0;
            hc_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            next_q  <= next_d;
            cnt_q   <= cnt_d;
            retry_q <= retry_d;
            loop_q  <= loop_d;
            v2_q    <= v2_d;
            hc_q    <= hc_d;
        end
    end

    assign init       = (state_q == ST_DONE);
    assign init_err   = (state_q == ST_ERROR);
    assign card_v2    = v2_q;
    assign card_hc    = hc_q;
    assign init_state = state_q;

endmodule

// File: tb/tb_sd_card_init.sv
// Directed bench for sd_card_init with a behavioural SPI SD card model.
// Honours SD_CCS_READ_EN for the expected CMD58 count.
module tb_sd_card_init;

  localparam int POWERUP_CYC = 160;
  localparam int RESP_TO     = 80;
`ifdef SD_CCS_READ_EN
  localparam int EXP_CMD58 = 1;
`else
  localparam int EXP_CMD58 = 0;
`endif

  logic       SD_clk = 1'b0;
  logic       rst = 1'b1;
  logic       SD_dataout = 1'b1;
  logic       SD_cs, SD_datain, init, init_err, card_v2, card_hc;
  logic [3:0] init_state;

  int n_assert = 0;
  int n_fail   = 0;

  // card configuration (written by the stimulus only)
  logic        card_dead = 1'b0;
  logic [7:0]  cmd8_r1   = 8'h01;
  logic [31:0] cmd8_echo = 32'h0000_01AA;
  int          acmd_busy_n = 2;
  logic [31:0] ocr = 32'hC0FF_8000;

  // card model / bus monitor state (written by the card process only)
  int          n_cmd0, n_cmd8, n_cmd55, n_acmd41, n_cmd58;
  logic [31:0] acmd41_arg;
  int          frames, low_len, min_low, max_low, high_first, rx_cnt;
  logic        seen_fall, prev_cs, app;
  logic [47:0] rx_sh;
  logic        bitq[$];
  logic        do_next = 1'b1;

  sd_card_init #(
    .POWERUP_CYC (POWERUP_CYC),
    .RESP_TIMEOUT(RESP_TO),
    .CMD_RETRY   (8),
    .ACMD41_MAX  (5)
  ) dut (
    .SD_clk    (SD_clk),
    .rst       (rst),
    .SD_dataout(SD_dataout),
    .SD_cs     (SD_cs),
    .SD_datain (SD_datain),
    .init      (init),
    .init_err  (init_err),
    .card_v2   (card_v2),
    .card_hc   (card_hc),
    .init_state(init_state)
  );

  // clock / reset block
  always #5 SD_clk = ~SD_clk;

  task automatic push_bits(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) bitq.push_back(v[i]);
  endtask

  // card reaction to a complete 48-bit command: one idle byte, then response
  task automatic card_cmd();
    logic [5:0] idx;
    idx = rx_sh[45:40];
    case (idx)
      6'd0: begin
        n_cmd0++; app = 1'b0;
        push_bits(32'hFF, 8); push_bits(32'h01, 8);
      end
      6'd8: begin
        n_cmd8++; app = 1'b0;
        push_bits(32'hFF, 8); push_bits({24'd0, cmd8_r1}, 8);
        if (cmd8_r1 == 8'h01) push_bits(cmd8_echo, 32);
      end
      6'd55: begin
        n_cmd55++; app = 1'b1;
        push_bits(32'hFF, 8); push_bits(32'h01, 8);
      end
      6'd41: begin
        if (app) begin
          n_acmd41++;
          acmd41_arg = rx_sh[39:8];
          push_bits(32'hFF, 8);
          push_bits((n_acmd41 > acmd_busy_n) ? 32'h00 : 32'h01, 8);
        end
        app = 1'b0;
      end
      6'd58: begin
        n_cmd58++; app = 1'b0;
        push_bits(32'hFF, 8); push_bits(32'h00, 8); push_bits(ocr, 32);
      end
      default: app = 1'b0;
    endcase
    if (card_dead) bitq.delete();
  endtask

  // card model: samples CS/DI on the rising edge, picks the next DO bit
  always @(posedge SD_clk) begin
    if (rst) begin
      n_cmd0 = 0; n_cmd8 = 0; n_cmd55 = 0; n_acmd41 = 0; n_cmd58 = 0;
      acmd41_arg = 32'hDEAD_BEEF;
      frames = 0; low_len = 0; min_low = 1000000; max_low = 0; high_first = 0;
      rx_cnt = 0; seen_fall = 1'b0; prev_cs = 1'b1; app = 1'b0; rx_sh = '0;
      bitq.delete();
      do_next = 1'b1;
    end else begin
      if (SD_cs == 1'b0) begin
        if (prev_cs) frames++;
        seen_fall = 1'b1;
        low_len++;
        if (rx_cnt < 48) begin
          rx_sh = {rx_sh[46:0], SD_datain};
          rx_cnt++;
          if (rx_cnt == 48) card_cmd();
        end
      end else begin
        if (!seen_fall) high_first++;
        if (low_len > 0) begin
          if (low_len < min_low) min_low = low_len;
          if (low_len > max_low) max_low = low_len;
          low_len = 0;
        end
        rx_cnt = 0;
        bitq.delete();
      end
      prev_cs = SD_cs;
      do_next = (bitq.size() > 0) ? bitq.pop_front() : 1'b1;
    end
  end

  // card drives DO on the falling edge
  always @(negedge SD_clk) SD_dataout = do_next;

  // driver tasks
  task automatic wait_clk(input int n);
    repeat (n) @(posedge SD_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic start_test(input string tag);
    rst = 1'b1;
    wait_clk(2);
    rst = 1'b0;
    wait_clk(1);
    check({tag, "_powerup_entry"}, 32'(init_state), 32'd1);
  endtask

  task automatic wait_end(input string tag, input int budget);
    int n;
    n = 0;
    while (!(init || init_err) && n < budget) begin
      wait_clk(1);
      n++;
    end
    check({tag, "_finished"}, 32'(n < budget), 32'd1);
    wait_clk(2);
  endtask

  // scoreboard sequence
  initial begin
    // reset state
    wait_clk(3);
    check("rst_cs", 32'(SD_cs), 32'd1);
    check("rst_di", 32'(SD_datain), 32'd1);
    check("rst_init", 32'(init), 32'd0);
    check("rst_err", 32'(init_err), 32'd0);
    check("rst_v2", 32'(card_v2), 32'd0);
    check("rst_hc", 32'(card_hc), 32'd0);
    check("rst_state", 32'(init_state), 32'd0);

    // v2 SDHC card
    card_dead = 1'b0; cmd8_r1 = 8'h01; cmd8_echo = 32'h0000_01AA; acmd_busy_n = 2; ocr = 32'hC0FF_8000;
    start_test("v2");
    wait_end("v2", 6000);
    check("v2_powerup_high", 32'(high_first >= POWERUP_CYC), 32'd1);
    check("v2_init", 32'(init), 32'd1);
    check("v2_err", 32'(init_err), 32'd0);
    check("v2_card_v2", 32'(card_v2), 32'd1);
    check("v2_card_hc", 32'(card_hc), 32'd1);
    check("v2_state", 32'(init_state), 32'd8);
    check("v2_cmd0", 32'(n_cmd0), 32'd1);
    check("v2_cmd55", 32'(n_cmd55), 32'd3);
    check("v2_acmd41", 32'(n_acmd41), 32'd3);
    check("v2_acmd41_arg", acmd41_arg, 32'h4000_0000);
    check("v2_cmd58", 32'(n_cmd58), 32'(EXP_CMD58));
    check("v2_cs_idle", 32'(SD_cs), 32'd1);
    wait_clk(30);
    check("v2_init_sticky", 32'(init), 32'd1);

    // v1 card: CMD8 rejected as illegal
    cmd8_r1 = 8'h05; acmd_busy_n = 1; ocr = 32'h80FF_8000;
    start_test("v1");
    wait_end("v1", 6000);
    check("v1_init", 32'(init), 32'd1);
    check("v1_card_v2", 32'(card_v2), 32'd0);
    check("v1_card_hc", 32'(card_hc), 32'd0);
    check("v1_acmd41_arg", acmd41_arg, 32'h0000_0000);
    check("v1_acmd41", 32'(n_acmd41), 32'd2);
    check("v1_cmd58", 32'(n_cmd58), 32'(EXP_CMD58));

    // dead card: DO stuck high
    card_dead = 1'b1; cmd8_r1 = 8'h01;
    start_test("dead");
    wait_end("dead", 6000);
    check("dead_err", 32'(init_err), 32'd1);
    check("dead_init", 32'(init), 32'd0);
    check("dead_cs", 32'(SD_cs), 32'd1);
    check("dead_state", 32'(init_state), 32'd9);
    check("dead_frames", 32'(frames), 32'd8);
    check("dead_cmd0", 32'(n_cmd0), 32'd8);
    check("dead_cmd8", 32'(n_cmd8), 32'd0);
    check("dead_min_low", 32'(min_low), 32'd128);
    check("dead_max_low", 32'(max_low), 32'd128);
    wait_clk(20);
    check("dead_err_sticky", 32'(init_err), 32'd1);

    // ACMD41 never leaves idle
    card_dead = 1'b0; acmd_busy_n = 1000;
    start_test("stuck");
    wait_end("stuck", 6000);
    check("stuck_err", 32'(init_err), 32'd1);
    check("stuck_init", 32'(init), 32'd0);
    check("stuck_cmd55", 32'(n_cmd55), 32'd5);
    check("stuck_acmd41", 32'(n_acmd41), 32'd5);
    check("stuck_cmd58", 32'(n_cmd58), 32'd0);

    // CMD8 echo mismatch
    acmd_busy_n = 2; cmd8_echo = 32'h0000_01AB;
    start_test("echo");
    wait_end("echo", 6000);
    check("echo_err", 32'(init_err), 32'd1);
    check("echo_cmd8", 32'(n_cmd8), 32'd1);
    check("echo_cmd55", 32'(n_cmd55), 32'd0);
    check("echo_card_v2", 32'(card_v2), 32'd0);

    // reset in the middle of an ACMD41 frame
    cmd8_echo = 32'h0000_01AA; acmd_busy_n = 2;
    start_test("midrst");
    begin
      int n;
      n = 0;
      while (!(init_state == 4'd5 && low_len == 20) && n < 4000) begin
        wait_clk(1);
        n++;
      end
      check("midrst_reached", 32'(n < 4000), 32'd1);
    end
    rst = 1'b1;
    wait_clk(1);
    check("midrst_cs", 32'(SD_cs), 32'd1);
    check("midrst_di", 32'(SD_datain), 32'd1);
    check("midrst_state", 32'(init_state), 32'd0);
    rst = 1'b0;
    wait_clk(1);
    check("midrst_powerup", 32'(init_state), 32'd1);
    wait_end("midrst", 6000);
    check("midrst_powerup_high", 32'(high_first >= POWERUP_CYC), 32'd1);
    check("midrst_cmd0", 32'(n_cmd0), 32'd1);
    check("midrst_init", 32'(init), 32'd1);
    check("midrst_card_hc", 32'(card_hc), 32'd1);

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
